// File: rtl/ps2_host_tx.sv
//------------------------------------------------------------------
// ps2_host_tx - PS/2 host-to-device command byte transmitter (rev 1.0)
//------------------------------------------------------------------
`default_nettype none

module ps2_host_tx #(
   parameter int INHIBIT_CYCLES = 5000,
   parameter int TIMEOUT_CYCLES = 750000
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       tx_valid,
   input  logic [7:0] tx_data,
   output logic       tx_ready,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic       ps2_clk_oe,
   output logic       ps2_data_oe,
   output logic       busy,
   output logic       tx_done,
   output logic       tx_err
);

   localparam int MAX_CYC = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
   localparam int CNT_W   = $clog2(MAX_CYC + 1);
   localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
   localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      INHIBIT   = 3'd1,
      RTS       = 3'd2,
      SEND      = 3'd3,
      ACK       = 3'd4,
      WAIT_IDLE = 3'd5
   } state_t;

   state_t           state, state_nx;
   logic [2:0]       clk_sync, data_sync;
   logic [CNT_W-1:0] cnt, cnt_nx;
   logic [3:0]       bitcnt, bitcnt_nx, bit_inc;
   logic [9:0]       frame, frame_nx;
   logic             clk_oe_nx, data_oe_nx, done_nx, err_nx;
   logic             fe, clk_s, data_s, timeout, accept;

   assign fe       = (clk_sync[2:1] == 2'b10);
   assign clk_s    = clk_sync[2];
   assign data_s   = data_sync[2];
   assign bit_inc  = bitcnt + 4'd1;
   assign timeout  = (cnt == TO_LAST);
   // Ready is withheld during the completion pulse so it rises one cycle later.
   assign tx_ready = (state == IDLE) && !tx_done && !tx_err;
   assign busy     = (state != IDLE);
   assign accept   = tx_valid && tx_ready;

   always_comb begin
      state_nx   = state;
      cnt_nx     = cnt + 1'b1;
      bitcnt_nx  = bitcnt;
      frame_nx   = frame;
      clk_oe_nx  = 1'b0;
      data_oe_nx = 1'b0;
      done_nx    = 1'b0;
      err_nx     = 1'b0;
      case (state)
         IDLE: begin
            cnt_nx = '0;
            if (accept) begin
               frame_nx  = {1'b1, ~^tx_data, tx_data};
               state_nx  = INHIBIT;
               clk_oe_nx = 1'b1;
            end
         end
         INHIBIT: begin
            clk_oe_nx = 1'b1;
            if (cnt == INH_LAST) begin
               state_nx   = RTS;
               cnt_nx     = '0;
               bitcnt_nx  = '0;
               clk_oe_nx  = 1'b0;
               data_oe_nx = 1'b1;
            end
         end
         RTS: begin
            data_oe_nx = 1'b1;
            bitcnt_nx  = '0;
            if (fe) begin
               state_nx   = SEND;
               cnt_nx     = '0;
               data_oe_nx = ~frame[0];
            end else if (timeout) begin
               state_nx   = IDLE;
               err_nx     = 1'b1;
               data_oe_nx = 1'b0;
            end
         end
         SEND: begin
            data_oe_nx = ~frame[bitcnt];
            if (fe) begin
               cnt_nx = '0;
               if (bitcnt == 4'd9) begin
                  state_nx   = ACK;
                  data_oe_nx = 1'b0;
               end else begin
                  bitcnt_nx  = bit_inc;
                  data_oe_nx = ~frame[bit_inc];
               end
            end else if (timeout) begin
               state_nx   = IDLE;
               err_nx     = 1'b1;
               data_oe_nx = 1'b0;
            end
         end
         ACK: begin
            if (fe) begin
               if (!data_s) begin
                  state_nx = WAIT_IDLE;
                  cnt_nx   = '0;
               end else begin
                  state_nx = IDLE;
                  err_nx   = 1'b1;
               end
            end else if (timeout) begin
               state_nx = IDLE;
               err_nx   = 1'b1;
            end
         end
         WAIT_IDLE: begin
            if (clk_s && data_s) begin
               state_nx = IDLE;
               done_nx  = 1'b1;
            end else if (fe) begin
               cnt_nx = '0;
            end else if (timeout) begin
               state_nx = IDLE;
               err_nx   = 1'b1;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state       <= IDLE;
         cnt         <= '0;
         bitcnt      <= '0;
         frame       <= '0;
         clk_sync    <= 3'b111;
         data_sync   <= 3'b111;
         ps2_clk_oe  <= 1'b0;
         ps2_data_oe <= 1'b0;
         tx_done     <= 1'b0;
         tx_err      <= 1'b0;
      end else begin
         state       <= state_nx;
         cnt         <= cnt_nx;
         bitcnt      <= bitcnt_nx;
         frame       <= frame_nx;
         clk_sync    <= {clk_sync[1:0], ps2_clk};
         data_sync   <= {data_sync[1:0], ps2_data};
         ps2_clk_oe  <= clk_oe_nx;
         ps2_data_oe <= data_oe_nx;
         tx_done     <= done_nx;
         tx_err      <= err_nx;
      end
   end

endmodule

`default_nettype wire
